// File: rtl/boot_loader_pkg.sv
// Shared types and frame constants for the UART boot loader.
// Optional checksum support is enabled by defining BOOT_LOADER_CHECKSUM_EN.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam int HDR_LEN        = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_loader_if.sv
// Byte stream in from the UART receiver and word write port out to text memory.
interface boot_loader_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_done;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;

    modport master (
        input  rx_data,
        input  rx_done,
        output mem_we,
        output mem_waddr,
        output mem_wdata
    );

    modport slave (
        output rx_data,
        output rx_done,
        input  mem_we,
        input  mem_waddr,
        input  mem_wdata
    );
endinterface

// File: rtl/boot_loader_byte_packer.sv
// Assembles little-endian 32-bit words from a byte stream; o_word_valid marks
// the cycle the fourth byte arrives, with o_word already complete in that cycle.
module byte_packer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [7:0]       i_byte,
    output logic [WIDTH-1:0] o_word,
    output logic             o_word_valid
);
    logic [1:0]       r_lane;
    logic [WIDTH-9:0] r_bytes;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_lane <= '0;
        end else if (i_en) begin
            r_lane <= r_lane + 2'd1;
        end
    end

    // Shift right so the first byte ends up in the lowest lane.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_bytes <= {i_byte, r_bytes[WIDTH-9:8]};
        end
    end

    assign o_word       = {i_byte, r_bytes};
    assign o_word_valid = i_en && (r_lane == 2'd3);

endmodule

// File: rtl/boot_loader.sv
// UART boot loader: frames a length-prefixed byte stream into text memory words
// and holds the CPU in reset meanwhile. Define BOOT_LOADER_CHECKSUM_EN for a trailing XOR byte.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic          clk,
    input  logic          rst,
    boot_loader_if.master bus,
    input  logic          i_load_req,
    output logic          o_cpu_rst,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);
    localparam int          TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [16:0] CAP   = 17'((2 ** ADDR_W) / BYTES_PER_WORD);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_len_lo;
    logic [15:0]       r_len;
    logic [15:0]       r_words;
    logic [ADDR_W-1:0] r_addr;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_waddr;
    logic [WIDTH-1:0]  r_mem_wdata;
    logic              r_cpu_rst;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_rx;
    logic [7:0]        w_byte;
    logic [15:0]       w_len;
    logic              w_last;
    logic              w_tmo_hit;
    logic              w_tmo_cnt;
    logic              w_enter_lo;
    logic              w_pk_en;
    logic [WIDTH-1:0]  w_word;
    logic              w_word_valid;
    logic              w_cpu_rst_nxt;
    logic              w_busy_nxt;
    logic              w_we_nxt;

    assign w_rx       = bus.rx_done;
    assign w_byte     = bus.rx_data;
    assign w_len      = {w_byte, r_len_lo};
    assign w_last     = (r_words == r_len);
    assign w_tmo_hit  = (r_tmo == TMO_W'(TIMEOUT));
    assign w_tmo_cnt  = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                        (r_state == DATA)   || (r_state == CHK);
    assign w_enter_lo = (w_state_nxt == LEN_LO) && (r_state != LEN_LO);
    // A byte landing in the WRITE cycle starts the next word unless this was the last one.
    assign w_pk_en    = w_rx && ((r_state == DATA) || ((r_state == WRITE) && !w_last));

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_LAST = CHK;
    logic [7:0] r_xor;
    logic       w_sum_ok;

    always_ff @(posedge clk) begin
        if (rst || (r_state == LEN_LO)) begin
            r_xor <= '0;
        end else if (w_pk_en) begin
            r_xor <= r_xor ^ w_byte;
        end
    end

    assign w_sum_ok = (w_byte == r_xor);
`else
    localparam state_t S_AFTER_LAST = DONE;
`endif

    byte_packer #(.WIDTH(WIDTH)) u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (r_state == LEN_LO),
        .i_en         (w_pk_en),
        .i_byte       (w_byte),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (i_load_req) w_state_nxt = LEN_LO;
            LEN_LO: begin
                if (w_rx)           w_state_nxt = LEN_HI;
                else if (w_tmo_hit) w_state_nxt = ERR;
            end
            LEN_HI: begin
                if (w_rx) begin
                    if (w_len == 16'd0)          w_state_nxt = S_AFTER_LAST;
                    else if ({1'b0, w_len} > CAP) w_state_nxt = ERR;
                    else                         w_state_nxt = DATA;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ERR;
                end
            end
            DATA: begin
                if (w_word_valid)   w_state_nxt = WRITE;
                else if (w_tmo_hit) w_state_nxt = ERR;
            end
            WRITE: begin
                if (w_last) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                    if (w_rx) w_state_nxt = w_sum_ok ? DONE : ERR;
                    else      w_state_nxt = CHK;
`else
                    w_state_nxt = DONE;
`endif
                end else begin
                    w_state_nxt = DATA;
                end
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            CHK: begin
                if (w_rx)           w_state_nxt = w_sum_ok ? DONE : ERR;
                else if (w_tmo_hit) w_state_nxt = ERR;
            end
`endif
            DONE: w_state_nxt = IDLE;
            ERR:  if (i_load_req) w_state_nxt = LEN_LO;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered below.
    always_comb begin
        w_cpu_rst_nxt = 1'b0;
        w_busy_nxt    = 1'b0;
        w_we_nxt      = 1'b0;
        case (w_state_nxt)
            LEN_LO, LEN_HI, DATA, CHK: begin
                w_cpu_rst_nxt = 1'b1;
                w_busy_nxt    = 1'b1;
            end
            WRITE: begin
                w_cpu_rst_nxt = 1'b1;
                w_busy_nxt    = 1'b1;
                w_we_nxt      = 1'b1;
            end
            ERR: w_cpu_rst_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_rst <= 1'b0;
            r_busy    <= 1'b0;
            r_mem_we  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_cpu_rst <= w_cpu_rst_nxt;
            r_busy    <= w_busy_nxt;
            r_mem_we  <= w_we_nxt;
            if (w_enter_lo)                r_done <= 1'b0;
            else if (w_state_nxt == DONE)  r_done <= 1'b1;
            if (w_enter_lo)                r_err  <= 1'b0;
            else if (w_state_nxt == ERR)   r_err  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_rx || w_enter_lo) begin
            r_tmo <= '0;
        end else if (w_tmo_cnt) begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == LEN_LO) && w_rx) r_len_lo <= w_byte;
        if ((r_state == LEN_HI) && w_rx) r_len    <= w_len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_words     <= '0;
            r_addr      <= '0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
        end else if (r_state == LEN_LO) begin
            r_words <= '0;
            r_addr  <= '0;
        end else if (w_word_valid) begin
            r_words     <= r_words + 16'd1;
            r_addr      <= r_addr + ADDR_W'(BYTES_PER_WORD);
            r_mem_waddr <= r_addr;
            r_mem_wdata <= w_word;
        end
    end

    assign bus.mem_we    = r_mem_we;
    assign bus.mem_waddr = r_mem_waddr;
    assign bus.mem_wdata = r_mem_wdata;
    assign o_cpu_rst     = r_cpu_rst;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader; covers both builds of BOOT_LOADER_CHECKSUM_EN.
module tb_boot_loader;
    import boot_loader_pkg::*;

    localparam int TMO = 40;

    logic clk = 1'b0;
    logic rst;
    logic load_req;
    logic cpu_rst;
    logic busy;
    logic done;
    logic err;

    int checks   = 0;
    int failures = 0;

    int          wr_cnt = 0;
    logic [7:0]  wr_addr [32];
    logic [31:0] wr_data [32];

    boot_loader_if #(.WIDTH(32), .ADDR_W(8)) bus ();

    boot_loader #(.WIDTH(32), .ADDR_W(8), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .i_load_req (load_req),
        .o_cpu_rst  (cpu_rst),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_addr[wr_cnt[4:0]] <= bus.mem_waddr;
            wr_data[wr_cnt[4:0]] <= bus.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        @(negedge clk);
        bus.rx_done = 1'b0;
    endtask

    task automatic send_header(input logic [15:0] n);
        for (int i = 0; i < HDR_LEN; i++) send_byte(n[8*i +: 8]);
    endtask

    task automatic pulse_load();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b want 0", bus.mem_we); end
        checks++; if (bus.mem_waddr !== 8'h00) begin failures++; $display("FAIL reset_waddr: got %h want 00", bus.mem_waddr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata: got %h want 0", bus.mem_wdata); end
        checks++; if (cpu_rst !== 1'b0) begin failures++; $display("FAIL reset_cpu_rst: got %b want 0", cpu_rst); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
        #1 base = wr_cnt;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h55);
        @(negedge clk); #1;
        checks++; if (wr_cnt !== base) begin failures++; $display("FAIL idle_rx_write: writes %0d want %0d", wr_cnt, base); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_rx_busy: got %b want 0", busy); end
    endtask

    task automatic test_download();
        int base;
        #1 base = wr_cnt;
        pulse_load();
        checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL dl_cpu_rst_rise: got %b want 1", cpu_rst); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL dl_busy_rise: got %b want 1", busy); end
        send_header(16'd2);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL dl_we_last: got %b want 1", bus.mem_we); end
        checks++; if (bus.mem_waddr !== 8'h04) begin failures++; $display("FAIL dl_waddr_last: got %h want 04", bus.mem_waddr); end
        checks++; if (bus.mem_wdata !== 32'h12345678) begin failures++; $display("FAIL dl_wdata_last: got %h want 12345678", bus.mem_wdata); end
        checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL dl_cpu_rst_write: got %b want 1", cpu_rst); end
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(8'h2A);
`else
        @(negedge clk);
`endif
        checks++; if (cpu_rst !== 1'b0) begin failures++; $display("FAIL dl_cpu_rst_fall: got %b want 0", cpu_rst); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL dl_done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dl_busy_fall: got %b want 0", busy); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL dl_we_after: got %b want 0", bus.mem_we); end
        #1;
        checks++; if (wr_cnt !== base + 2) begin failures++; $display("FAIL dl_write_count: got %0d want %0d", wr_cnt, base + 2); end
        checks++; if (wr_addr[base[4:0]] !== 8'h00 || wr_data[base[4:0]] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL dl_word0: got %h@%h want deadbeef@00", wr_data[base[4:0]], wr_addr[base[4:0]]); end
        checks++; if (wr_addr[base[4:0] + 5'd1] !== 8'h04 || wr_data[base[4:0] + 5'd1] !== 32'h12345678) begin
            failures++; $display("FAIL dl_word1: got %h@%h want 12345678@04", wr_data[base[4:0] + 5'd1], wr_addr[base[4:0] + 5'd1]); end
    endtask

    task automatic test_range_err();
        int base;
        #1 base = wr_cnt;
        pulse_load();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rng_done_clear: got %b want 0", done); end
        send_header(16'h0041);
        @(negedge clk); #1;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL rng_err: got %b want 1", err); end
        checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL rng_cpu_rst: got %b want 1", cpu_rst); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rng_busy: got %b want 0", busy); end
        checks++; if (wr_cnt !== base) begin failures++; $display("FAIL rng_no_write: got %0d want %0d", wr_cnt, base); end
        pulse_load();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rng_err_clear: got %b want 0", err); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rng_reload_busy: got %b want 1", busy); end
        send_header(16'd1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(8'h44);
`endif
        repeat (2) @(negedge clk); #1;
        checks++; if (done !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL rng_recover: done=%b err=%b want 1/0", done, err); end
        checks++; if (wr_cnt !== base + 1 || wr_data[base[4:0]] !== 32'h44332211 || wr_addr[base[4:0]] !== 8'h00) begin
            failures++; $display("FAIL rng_recover_word: n=%0d got %h@%h want 44332211@00", wr_cnt - base, wr_data[base[4:0]], wr_addr[base[4:0]]); end
    endtask

    task automatic test_max_len_abort();
        pulse_load();
        send_header(16'h0040);
        send_byte(8'hAA);
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL max_len_accept: err=%b busy=%b want 0/1", err, busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (cpu_rst !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_rst: cpu_rst=%b busy=%b want 0/0", cpu_rst, busy); end
        rst = 1'b0;
    endtask

    task automatic test_timeout();
        int base;
        #1 base = wr_cnt;
        pulse_load();
        send_header(16'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (TMO / 2) @(negedge clk);
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL tmo_early: err=%b busy=%b want 0/1", err, busy); end
        repeat (2 * TMO) @(negedge clk);
        #1;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL tmo_err: got %b want 1", err); end
        checks++; if (cpu_rst !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL tmo_ctrl: cpu_rst=%b busy=%b want 1/0", cpu_rst, busy); end
        checks++; if (wr_cnt !== base) begin failures++; $display("FAIL tmo_no_write: got %0d want %0d", wr_cnt, base); end
    endtask

    task automatic test_back_to_back();
        int base;
        #1 base = wr_cnt;
        pulse_load();
        send_header(16'd2);
        @(negedge clk);
        bus.rx_done = 1'b1;
        bus.rx_data = 8'h01;
        @(negedge clk); bus.rx_data = 8'h02;
        @(negedge clk); bus.rx_data = 8'h03;
        @(negedge clk); bus.rx_data = 8'h04;
        @(negedge clk);
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h04030201) begin
            failures++; $display("FAIL b2b_word0: we=%b data=%h want 1/04030201", bus.mem_we, bus.mem_wdata); end
        bus.rx_data = 8'h05;
        @(negedge clk);
        bus.rx_done = 1'b0;
        send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h08070605 || bus.mem_waddr !== 8'h04) begin
            failures++; $display("FAIL b2b_word1: we=%b data=%h addr=%h want 1/08070605/04", bus.mem_we, bus.mem_wdata, bus.mem_waddr); end
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(8'h08);
`endif
        repeat (2) @(negedge clk); #1;
        checks++; if (done !== 1'b1 || wr_cnt !== base + 2) begin failures++; $display("FAIL b2b_done: done=%b writes=%0d want 1/%0d", done, wr_cnt - base, 2); end
    endtask

    task automatic test_zero_len();
        int base;
        #1 base = wr_cnt;
        pulse_load();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_clear: got %b want 0", done); end
        send_header(16'd0);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        repeat (2) @(negedge clk); #1;
        checks++; if (done !== 1'b1 || err !== 1'b0 || cpu_rst !== 1'b0) begin
            failures++; $display("FAIL zero_len: done=%b err=%b cpu_rst=%b want 1/0/0", done, err, cpu_rst); end
        checks++; if (wr_cnt !== base) begin failures++; $display("FAIL zero_no_write: got %0d want %0d", wr_cnt, base); end
    endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int base;
        pulse_load();
        send_header(16'd1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h44);
        @(negedge clk);
        checks++; if (done !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL chk_good: done=%b err=%b want 1/0", done, err); end
        #1 base = wr_cnt;
        pulse_load();
        send_header(16'd1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h45);
        @(negedge clk); #1;
        checks++; if (err !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1) begin
            failures++; $display("FAIL chk_bad: err=%b done=%b cpu_rst=%b want 1/0/1", err, done, cpu_rst); end
        checks++; if (wr_cnt !== base + 1 || wr_data[base[4:0]] !== 32'h44332211 || wr_addr[base[4:0]] !== 8'h00) begin
            failures++; $display("FAIL chk_bad_word: n=%0d got %h@%h want 44332211@00", wr_cnt - base, wr_data[base[4:0]], wr_addr[base[4:0]]); end
    endtask
`endif

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        load_req    = 1'b0;
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        test_reset();
        test_download();
        test_range_err();
        test_max_len_abort();
        test_timeout();
        test_back_to_back();
        test_zero_len();
`ifdef BOOT_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
